aes_decryption_multicycle: RTL and testbench

Iterative AES-256 inverse cipher (FIPS-197 §5.3): accepts one 128-bit ciphertext block plus the 15-entry round-key chain from `key_expansion`, and produces the plaintext. It applies one inverse round per clock through a single shared round datapath. It is the receive-side counterpart of the pipelined encryption core and sits behind the same `key_expansion` instance. It trades throughput (one block per ≥15 cycles) for area.

---
 rtl/aes_pkg.sv | 64 ++++++
 rtl/aes_decryption_multicycle_inv_round.sv | 37 +++
 rtl/aes_decryption_multicycle.sv | 87 ++++++++
 tb/tb_aes_decryption_multicycle.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES inverse cipher.
package aes_pkg;

  localparam int unsigned round_key_w_c = 128;
  localparam int unsigned num_rounds_c  = 14;
  localparam int unsigned key_chain_w_c = round_key_w_c * (num_rounds_c + 1);
  localparam int unsigned round_cnt_w_c = 4;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_dec_state_e;

  // Inverse S-box; entry x is inv_sbox_c[x].
  localparam logic [0:255][7:0] inv_sbox_c = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Multiply by x modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Source byte index for InvShiftRows: row r of column c comes from column (c - r) mod 4.
  function automatic int unsigned inv_shift_src(input int unsigned i);
    int unsigned col;
    int unsigned row;
    col = i / 4;
    row = i % 4;
    return 4 * ((col + 4 - row) % 4) + row;
  endfunction

endpackage

// File: rtl/aes_decryption_multicycle_inv_round.sv
// One AES inverse round, purely combinational.
module aes_inv_round
  import aes_pkg::*;
(
  input  aes_block_t state,
  input  aes_block_t key,
  input  logic       last_round,
  output aes_block_t next_state_c
);

  logic [7:0] sub_b [16];
  logic [7:0] ark_b [16];
  logic [7:0] mix_b [16];

  // InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped on the last round).
  always_comb begin
    next_state_c = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      sub_b[i] = inv_sbox_c[state[127 - 8 * inv_shift_src(i) -: 8]];
      ark_b[i] = sub_b[i] ^ key[127 - 8 * i -: 8];
    end
    for (int unsigned c = 0; c < 4; c++) begin
      mix_b[4*c+0] = gmul(ark_b[4*c+0], 8'h0e) ^ gmul(ark_b[4*c+1], 8'h0b)
                   ^ gmul(ark_b[4*c+2], 8'h0d) ^ gmul(ark_b[4*c+3], 8'h09);
      mix_b[4*c+1] = gmul(ark_b[4*c+0], 8'h09) ^ gmul(ark_b[4*c+1], 8'h0e)
                   ^ gmul(ark_b[4*c+2], 8'h0b) ^ gmul(ark_b[4*c+3], 8'h0d);
      mix_b[4*c+2] = gmul(ark_b[4*c+0], 8'h0d) ^ gmul(ark_b[4*c+1], 8'h09)
                   ^ gmul(ark_b[4*c+2], 8'h0e) ^ gmul(ark_b[4*c+3], 8'h0b);
      mix_b[4*c+3] = gmul(ark_b[4*c+0], 8'h0b) ^ gmul(ark_b[4*c+1], 8'h0d)
                   ^ gmul(ark_b[4*c+2], 8'h09) ^ gmul(ark_b[4*c+3], 8'h0e);
    end
    for (int unsigned i = 0; i < 16; i++) begin
      next_state_c[127 - 8 * i -: 8] = last_round ? ark_b[i] : mix_b[i];
    end
  end

endmodule

// File: rtl/aes_decryption_multicycle.sv
// Iterative AES-256 inverse cipher: one inverse round per clock through a shared datapath.
module aes_decryption_multicycle
  import aes_pkg::*;
#(
  parameter int unsigned num_rounds_p = 14
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  output logic                     ready_o,
  input  logic [127:0]             ciphertext_i,
  input  logic [key_chain_w_c-1:0] key_chain_i,
  output logic                     v_o,
  input  logic                     yumi_i,
  output logic [127:0]             plaintext_o
);

  if (num_rounds_p != num_rounds_c) begin : g_bad_rounds
    $error("aes_decryption_multicycle supports only 14 rounds (AES-256)");
  end

  aes_dec_state_e           fsm_q, fsm_d;
  logic [round_cnt_w_c-1:0] r_q, r_d;
  aes_block_t               state_q, state_d;
  aes_block_t               rk_tab [16];
  aes_block_t               round_out;

  // Split the key chain into round keys; slot 15 is unreachable and tied off.
  for (genvar k = 0; k < 15; k++) begin : g_rk
    assign rk_tab[k] = key_chain_i[key_chain_w_c - 1 - round_key_w_c * k -: round_key_w_c];
  end
  assign rk_tab[15] = '0;

  aes_inv_round u_round (
    .state        (state_q),
    .key          (rk_tab[r_q]),
    .last_round   (r_q == '0),
    .next_state_c (round_out)
  );

  // Next-state, counter and datapath selection.
  always_comb begin
    fsm_d   = fsm_q;
    r_d     = r_q;
    state_d = state_q;
    unique case (fsm_q)
      ST_IDLE: begin
        if (v_i && ready_o) begin
          state_d = ciphertext_i ^ rk_tab[num_rounds_c];
          r_d     = round_cnt_w_c'(num_rounds_c - 1);
          fsm_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        state_d = round_out;
        if (r_q == '0) fsm_d = ST_DONE;
        else           r_d   = r_q - round_cnt_w_c'(1);
      end
      ST_DONE: begin
        if (yumi_i) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // State registers; handshake flags are registered decodes of the next FSM state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fsm_q   <= ST_IDLE;
      r_q     <= '0;
      state_q <= '0;
      ready_o <= 1'b1;
      v_o     <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      r_q     <= r_d;
      state_q <= state_d;
      ready_o <= (fsm_d == ST_IDLE);
      v_o     <= (fsm_d == ST_DONE);
    end
  end

  assign plaintext_o = state_q;

  a_yumi_only_with_v: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_aes_decryption_multicycle.sv
// Scoreboard bench for the iterative AES-256 inverse cipher using published known-answer vectors.
module tb_aes_decryption_multicycle;

  typedef struct packed {
    logic [127:0] pt;
    int unsigned  acc;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset_i = 1'b1;
  logic           v_i = 1'b0;
  logic           yumi_i = 1'b0;
  logic [127:0]   ciphertext_i = '0;
  logic [1919:0]  key_chain_i = '0;
  logic           ready_o;
  logic           v_o;
  logic [127:0]   plaintext_o;

  int unsigned    checks = 0;
  int unsigned    errors = 0;
  int unsigned    cyc = 0;
  int unsigned    vo_count = 0;
  logic           vo_prev = 1'b0;
  bit             ready_while_busy = 1'b0;
  exp_t           sb [$];
  logic [7:0]     sbox_tb [256];

  localparam logic [255:0] c3_key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] c3_ct  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] c3_pt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] sp_key = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic [127:0] sp_ct [4] = '{128'hf3eed1bdb5d2a03c064b5a7e3db181f8, 128'h591ccb10d410ed26dc5ba74a31362870,
                              128'hb6ed21b99ca6f4f9f153e7b1beafed1d, 128'h23304b7a39f9f3ff067d8d8f9e24ecc7};
  logic [127:0] sp_pt [4] = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                              128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};

  logic [1919:0] c3_chain;
  logic [1919:0] sp_chain;

  aes_decryption_multicycle #(.num_rounds_p(14)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .v_i          (v_i),
    .ready_o      (ready_o),
    .ciphertext_i (ciphertext_i),
    .key_chain_i  (key_chain_i),
    .v_o          (v_o),
    .yumi_i       (yumi_i),
    .plaintext_o  (plaintext_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul_tb(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // Forward S-box from first principles: multiplicative inverse, then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul_tb(inv, 8'(x));
      end
      sbox_tb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_tb[w[31:24]], sbox_tb[w[23:16]], sbox_tb[w[15:8]], sbox_tb[w[7:0]]};
  endfunction

  // AES-256 key expansion; round key k lands at [1919-128k -: 128].
  function automatic logic [1919:0] expand(input logic [255:0] key);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] ch;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul_tb(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subword(t);
      end
      w[i] = w[i-8] ^ t;
    end
    ch = '0;
    for (int k = 0; k < 15; k++) ch[1919 - 128 * k -: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    return ch;
  endfunction

  // Monitor: compare every rising v_o against the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset_i !== 1'b1) begin
      if (sb.size() > 0 && v_o !== 1'b1 && ready_o !== 1'b0) ready_while_busy = 1'b1;
      if (v_o === 1'b1 && vo_prev !== 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_output", plaintext_o, 128'hx);
        end else begin
          e = sb.pop_front();
          check("plaintext", plaintext_o, e.pt);
          check("latency", 128'(cyc - e.acc), 128'(14));
          check("ready_low_while_busy", 128'(ready_while_busy), 128'(0));
          ready_while_busy = 1'b0;
        end
      end
      if (v_o === 1'b1) vo_count++;
    end
    vo_prev = v_o;
  end

  // One block: accept, optional noise on v_i/ciphertext_i during ROUND, optional DONE backpressure.
  task automatic run_block(input logic [127:0] ct, input logic [127:0] pt, input int hold, input bit noise);
    int n;
    bit ok;
    n = 0;
    while (ready_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 128'(ready_o), 128'(1));
    if (ready_o !== 1'b1) return;
    ciphertext_i = ct;
    v_i = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{pt: pt, acc: cyc});
    v_i = 1'b0;
    @(negedge clk);
    n = 0;
    while (v_o !== 1'b1 && n < 30) begin
      if (noise) begin
        v_i = 1'($urandom_range(0, 1));
        ciphertext_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      @(negedge clk);
      n++;
    end
    v_i = 1'b0;
    check("vo_timeout", 128'(v_o), 128'(1));
    if (v_o !== 1'b1) return;
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      v_i = 1'b1;
      ciphertext_i = ~ct;
      @(negedge clk);
      if (v_o !== 1'b1 || ready_o !== 1'b0 || plaintext_o !== pt) ok = 1'b0;
    end
    v_i = 1'b0;
    if (hold > 0) check("backpressure_hold", 128'(ok), 128'(1));
    yumi_i = 1'b1;
    @(negedge clk);
    yumi_i = 1'b0;
    check("release_to_idle", 128'({v_o, ready_o}), 128'(2'b01));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    int          idx;
    int unsigned acc_prev;
    int unsigned vo0;
    bit          pend;

    build_sbox();
    c3_chain = expand(c3_key);
    sp_chain = expand(sp_key);

    // Reset values
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    check("reset_ready", 128'(ready_o), 128'(1));
    check("reset_v", 128'(v_o), 128'(0));
    check("reset_plaintext", plaintext_o, 128'h0);

    // FIPS-197 C.3
    key_chain_i = c3_chain;
    run_block(c3_ct, c3_pt, 0, 1'b0);

    // SP 800-38A ECB-AES256, with backpressure and in-flight noise on some blocks
    key_chain_i = sp_chain;
    run_block(sp_ct[0], sp_pt[0], 0, 1'b0);
    run_block(sp_ct[1], sp_pt[1], 20, 1'b0);
    run_block(sp_ct[2], sp_pt[2], 0, 1'b1);
    run_block(sp_ct[3], sp_pt[3], 3, 1'b1);

    // Back-to-back: v_i held high, yumi answers v_o immediately.
    // Period is accept edge + 14 round edges + one DONE edge = 16 edges.
    idx = 0;
    acc_prev = 0;
    vo0 = vo_count;
    for (int n = 0; n < 150; n++) begin
      if (idx == 4 && sb.size() == 0 && v_o !== 1'b1) break;
      yumi_i = v_o;
      pend = (ready_o === 1'b1) && (idx < 4);
      if (pend) ciphertext_i = sp_ct[idx];
      v_i = (idx < 4);
      @(posedge clk);
      #1;
      if (pend) begin
        sb.push_back('{pt: sp_pt[idx], acc: cyc});
        if (idx > 0) check("accept_spacing", 128'(cyc - acc_prev), 128'(16));
        acc_prev = cyc;
        idx++;
      end
      @(negedge clk);
    end
    v_i = 1'b0;
    yumi_i = 1'b0;
    check("b2b_blocks_accepted", 128'(idx), 128'(4));
    check("b2b_single_cycle_v", 128'(vo_count - vo0), 128'(4));

    // Reset mid-ROUND discards the block, then a clean decrypt follows
    key_chain_i = c3_chain;
    ciphertext_i = c3_ct;
    v_i = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{pt: c3_pt, acc: cyc});
    v_i = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    sb.delete();
    ready_while_busy = 1'b0;
    @(negedge clk);
    check("midreset_ready", 128'(ready_o), 128'(1));
    check("midreset_v", 128'(v_o), 128'(0));
    check("midreset_plaintext", plaintext_o, 128'h0);
    run_block(c3_ct, c3_pt, 0, 1'b1);

    repeat (20) @(negedge clk);
    check("scoreboard_empty", 128'(sb.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
